// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// It keeps small shadow copies of the EX/MEM/WB destination and source fields.
// From those it drives the operand-forwarding selects.
// It also resolves stall, flush and freeze in this priority order:
// memory wait > taken branch > load-use.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        ex_branch_taken,
    input  logic        dm_req,
    input  logic        dm_ready,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        ctrl_zero,
    output logic        pipe_freeze,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hz_state_t;

    localparam logic [1:0]  FWD_RF    = 2'b00;
    localparam logic [1:0]  FWD_EXMEM = 2'b01;
    localparam logic [1:0]  FWD_MEMWB = 2'b10;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    hz_state_t   r_state;
    hz_state_t   w_state_nxt;

    // Shadow pipeline fields
    logic [4:0]  r_ex_rs1;
    logic [4:0]  r_ex_rs2;
    logic [4:0]  r_ex_rd;
    logic        r_ex_regwrite;
    logic        r_ex_memread;
    logic [4:0]  r_mem_rd;
    logic        r_mem_regwrite;
    logic [4:0]  r_wb_rd;
    logic        r_wb_regwrite;

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_freeze_c;
    logic        w_load_use;
    logic        w_bubble;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_ifid_flush;
    logic        w_ctrl_zero;
    logic        w_pipe_freeze;

    // The newest producer (EX/MEM) wins over the older one (MEM/WB).
    // x0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return FWD_EXMEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_RF;
        end
    endfunction

    // Operand forwarding selects for the instruction currently in EX
    always_comb begin
        fwd_a_sel = fwd_sel(r_ex_rs1, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
        fwd_b_sel = fwd_sel(r_ex_rs2, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
    end

    // Hazard conditions seen this cycle
    always_comb begin
        w_freeze_c = dm_req & ~dm_ready;
        w_load_use = id_valid & r_ex_memread & (r_ex_rd != 5'd0) &
                     ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
    end

    // Next-state and pipeline controls, prioritised: freeze > branch > load-use
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt   = ST_RUN;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_ctrl_zero   = 1'b0;
        w_pipe_freeze = 1'b0;
        if (w_freeze_c) begin
            w_state_nxt   = ST_MEM_WAIT;
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_ctrl_zero  = 1'b1;
        end else if (w_load_use) begin
            w_state_nxt  = ST_LU_STALL;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ctrl_zero  = 1'b1;
        end
    end

    // Controls are forced inactive while reset is asserted, without waiting for a clock
    always_comb begin
        pc_write    = rst & w_pc_write;
        ifid_write  = rst & w_ifid_write;
        ifid_flush  = rst & w_ifid_flush;
        ctrl_zero   = rst & w_ctrl_zero;
        pipe_freeze = rst & w_pipe_freeze;
        w_bubble    = w_ctrl_zero | ~id_valid | w_ifid_flush;
        hz_state    = r_state;
        stall_cnt   = r_stall_cnt;
        flush_cnt   = r_flush_cnt;
    end

    // Hazard state register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow pipeline: advance unless frozen, with a bubble injected into EX when needed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_rs1       <= 5'd0;
            r_ex_rs2       <= 5'd0;
            r_ex_rd        <= 5'd0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_rd       <= 5'd0;
            r_mem_regwrite <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_regwrite  <= 1'b0;
        end else if (!w_pipe_freeze) begin
            if (w_bubble) begin
                r_ex_rs1      <= 5'd0;
                r_ex_rs2      <= 5'd0;
                r_ex_rd       <= 5'd0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_rs1      <= id_rs1;
                r_ex_rs2      <= id_rs2;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
            end
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_ifid_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl, plus hand-written reset and saturation sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_branch_taken;
    logic        dm_req;
    logic        dm_ready;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        ctrl_zero;
    logic        pipe_freeze;
    logic [1:0]  hz_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Control output groups {pc_write, ifid_write, ifid_flush, ctrl_zero, pipe_freeze}
    localparam logic [4:0] C_NORM = 5'b11000;
    localparam logic [4:0] C_LU   = 5'b00010;
    localparam logic [4:0] C_FRZ  = 5'b00001;
    localparam logic [4:0] C_BR   = 5'b11110;

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        br;
        logic        req;
        logic        rdy;
        logic [42:0] exp;
    } vec_t;

    vec_t tbl [23];

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .dm_req          (dm_req),
        .dm_ready        (dm_ready),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .ctrl_zero       (ctrl_zero),
        .pipe_freeze     (pipe_freeze),
        .hz_state        (hz_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input int v, input int rs1, input int rs2, input int rd,
        input int rw, input int mr, input int br, input int req, input int rdy,
        input int fa, input int fb, input logic [4:0] ctl,
        input int hz, input int sc, input int fc
    );
        vec_t r;
        r.v   = 1'(v);
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.rd  = 5'(rd);
        r.rw  = 1'(rw);
        r.mr  = 1'(mr);
        r.br  = 1'(br);
        r.req = 1'(req);
        r.rdy = 1'(rdy);
        r.exp = {2'(fa), 2'(fb), ctl, 2'(hz), 16'(sc), 16'(fc)};
        return r;
    endfunction

    function automatic logic [42:0] outs();
        return {fwd_a_sel, fwd_b_sel, pc_write, ifid_write, ifid_flush,
                ctrl_zero, pipe_freeze, hz_state, stall_cnt, flush_cnt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid        = x.v;
        id_rs1          = x.rs1;
        id_rs2          = x.rs2;
        id_rd           = x.rd;
        id_regwrite     = x.rw;
        id_memread      = x.mr;
        ex_branch_taken = x.br;
        dm_req          = x.req;
        dm_ready        = x.rdy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        v rs1 rs2 rd rw mr br rq ry | fa fb ctl    hz sc fc
        tbl[0]  = mk(1, 1,  2,  5, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 0, 0); // add x5
        tbl[1]  = mk(1, 5,  3,  6, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 0, 0); // sub x6 uses x5
        tbl[2]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 0, C_NORM, 0, 0, 0); // x5 from EX/MEM
        tbl[3]  = mk(1, 6,  5,  9, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 0, 0); // and uses x6 after nop
        tbl[4]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  2, 0, C_NORM, 0, 0, 0); // x6 from MEM/WB
        tbl[5]  = mk(1, 1,  0,  7, 1, 1, 0, 0, 0,  0, 0, C_NORM, 0, 0, 0); // lw x7
        tbl[6]  = mk(1, 4,  7, 10, 1, 0, 0, 0, 0,  0, 0, C_LU,   0, 0, 0); // load-use on rs2
        tbl[7]  = mk(1, 4,  7, 10, 1, 0, 0, 0, 0,  0, 0, C_NORM, 1, 1, 0); // LU_STALL, no repeat
        tbl[8]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 2, C_NORM, 0, 1, 0); // x7 from MEM/WB
        tbl[9]  = mk(1, 0,  0,  0, 1, 1, 0, 0, 0,  0, 0, C_NORM, 0, 1, 0); // lw x0
        tbl[10] = mk(1, 0,  0, 11, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 1, 0); // uses x0: no stall
        tbl[11] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, C_NORM, 0, 1, 0); // x0 in MEM: no fwd
        tbl[12] = mk(1, 11, 11, 12, 1, 0, 0, 1, 0,  0, 0, C_FRZ,  0, 1, 0); // mem wait 1
        tbl[13] = mk(1, 11, 11, 12, 1, 0, 0, 1, 0,  0, 0, C_FRZ,  2, 2, 0); // mem wait 2
        tbl[14] = mk(1, 11, 11, 12, 1, 0, 1, 1, 0,  0, 0, C_FRZ,  2, 3, 0); // branch held in wait
        tbl[15] = mk(1, 11, 11, 12, 1, 0, 1, 1, 1,  0, 0, C_BR,   2, 4, 0); // release: flush now
        tbl[16] = mk(1, 0,  0, 13, 1, 1, 0, 0, 0,  0, 0, C_NORM, 0, 4, 1); // lw x13
        tbl[17] = mk(1, 13, 0, 14, 1, 0, 1, 0, 0,  0, 0, C_BR,   0, 4, 1); // branch beats load-use
        tbl[18] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, C_NORM, 0, 4, 2); // no LU_STALL
        tbl[19] = mk(1, 0,  0, 15, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 4, 2); // x15 older write
        tbl[20] = mk(1, 0,  0, 15, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 4, 2); // x15 newer write
        tbl[21] = mk(1, 15, 15, 16, 1, 0, 0, 0, 0,  0, 0, C_NORM, 0, 4, 2); // consumer of x15
        tbl[22] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,  1, 1, C_NORM, 0, 4, 2); // EX/MEM wins over WB

        // Reset held with hazard-looking inputs: every output stays inactive
        rst = 1'b0;
        drive(mk(1, 3, 3, 3, 1, 1, 1, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end

        // Reset in the middle of LU_STALL
        @(negedge clk);
        drive(mk(1, 0, 0, 20, 1, 1, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 20, 0, 21, 1, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));
        #1;
        check("lu_ctl", 64'({pc_write, ifid_write, ifid_flush, ctrl_zero, pipe_freeze}), 64'(C_LU));
        @(negedge clk);
        #1;
        check("lu_state", 64'({hz_state, stall_cnt}), 64'({2'b01, 16'd5}));
        #2 rst = 1'b0;
        #1;
        check("rst_in_lu", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("run_after_lu_rst", 64'({hz_state, pc_write}), 64'({2'b00, 1'b1}));

        // Reset in the middle of MEM_WAIT, with the memory request still pending
        drive(mk(1, 1, 0, 2, 1, 0, 0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("memwait_state", 64'({hz_state, pipe_freeze, stall_cnt}), 64'({2'b10, 1'b1, 16'd1}));
        #2 rst = 1'b0;
        #1;
        check("rst_in_memwait", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("run_after_mw_rst", 64'({hz_state, pc_write, pipe_freeze, stall_cnt}),
              64'({2'b00, 1'b1, 1'b0, 16'd0}));

        // Long memory wait: stall counter saturates instead of wrapping
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b0, 0, 0, 0));
        repeat (65540) @(negedge clk);
        #1;
        check("stall_saturate", 64'({hz_state, stall_cnt}), 64'({2'b10, 16'hFFFF}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
